// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: opcodes, FSM states,
// mux selects, trap causes and the opcode-class decode helper.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JALR   = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_FUNCT = 2'd1,
        ALU_CMP   = 2'd2
    } alu_op_t;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'd0,
        TRAP_ILLEGAL = 2'd1,
        TRAP_IMEM    = 2'd2,
        TRAP_DMEM    = 2'd3
    } trap_cause_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_R       = 3'd1,
        CLS_OP_IMM  = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_BRANCH  = 3'd5,
        CLS_JAL     = 3'd6,
        CLS_LUI     = 3'd7
    } op_class_t;

    function automatic op_class_t decode_class(input logic [6:0] opc);
        op_class_t cls;
        case (opc)
            OPC_R:      cls = CLS_R;
            OPC_OP_IMM: cls = CLS_OP_IMM;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            OPC_LUI:    cls = CLS_LUI;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on a memory handshake; expired is
// high during the MEM_TIMEOUT-th waiting cycle.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = 8;

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // cnt_q holds the number of waiting cycles already completed
    assign expired = (cnt_q == TW'(MEM_TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/exec/mem/writeback sequencing
// with bounded-wait memory handshakes and a sticky trap state.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_b_sel,
    output logic [1:0]       alu_op,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_o
);

    state_t           state_q, state_d;
    op_class_t        class_q, class_d;
    logic             taken_q, taken_d;
    logic             trap_q, trap_d;
    trap_cause_t      cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expired(tmr_expired)
    );

    // The timer restarts whenever a waiting state is freshly entered
    assign tmr_clr = (state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM));

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        taken_d   = taken_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        instret_d = instret_q;
        tmr_en    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    state_d = ST_DECODE;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        state_d = ST_TRAP;
                        trap_d  = 1'b1;
                        cause_d = TRAP_IMEM;
                    end
                end
            end
            ST_DECODE: begin
                class_d = decode_class(opcode);
                if (class_d == CLS_ILLEGAL) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = TRAP_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                taken_d = (class_q == CLS_BRANCH) && br_taken;
                if ((class_q == CLS_LOAD) || (class_q == CLS_STORE)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_d = ST_WB;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        state_d = ST_TRAP;
                        trap_d  = 1'b1;
                        cause_d = TRAP_DMEM;
                    end
                end
            end
            ST_WB: begin
                instret_d = instret_q + CNT_W'(1);
                state_d   = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            class_q   <= CLS_ILLEGAL;
            taken_q   <= 1'b0;
            trap_q    <= 1'b0;
            cause_q   <= TRAP_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            taken_q   <= taken_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    pc_sel_t pc_sel_c;
    alu_op_t alu_op_c;
    wb_sel_t wb_sel_c;

    // Outputs are forced low while reset is asserted so an in-flight
    // request or write strobe cannot leak through the reset cycle.
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel_c  = PC_PLUS4;
        alu_b_sel = 1'b0;
        alu_op_c  = ALU_ADD;
        dmem_rd   = 1'b0;
        dmem_wr   = 1'b0;
        reg_we    = 1'b0;
        wb_sel_c  = WB_ALU;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                ST_EXEC: begin
                    alu_b_sel = (class_q == CLS_OP_IMM) || (class_q == CLS_LOAD) ||
                                (class_q == CLS_STORE);
                    case (class_q)
                        CLS_R, CLS_OP_IMM: alu_op_c = ALU_FUNCT;
                        CLS_BRANCH:        alu_op_c = ALU_CMP;
                        default:           alu_op_c = ALU_ADD;
                    endcase
                end
                ST_MEM: begin
                    dmem_rd = (class_q == CLS_LOAD);
                    dmem_wr = (class_q == CLS_STORE);
                end
                ST_WB: begin
                    pc_we = 1'b1;
                    if ((class_q == CLS_JAL) || ((class_q == CLS_BRANCH) && taken_q)) begin
                        pc_sel_c = PC_BRANCH;
                    end
                    reg_we = (class_q != CLS_STORE) && (class_q != CLS_BRANCH);
                    case (class_q)
                        CLS_LOAD: wb_sel_c = WB_MEM;
                        CLS_JAL:  wb_sel_c = WB_LINK;
                        CLS_LUI:  wb_sel_c = WB_IMM;
                        default:  wb_sel_c = WB_ALU;
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    assign pc_sel     = pc_sel_c;
    assign alu_op     = alu_op_c;
    assign wb_sel     = wb_sel_c;
    assign trap       = trap_q && !reset;
    assign trap_cause = reset ? 2'b00 : cause_q;
    assign instret    = reset ? '0 : instret_q;
    assign state_o    = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level schedule model
// predicts the phase and control outputs of every cycle.
module tb_multicycle_ctrl;

    localparam int T  = 16;
    localparam int CW = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam int P_FETCH  = 0;
    localparam int P_DECODE = 1;
    localparam int P_EXEC   = 2;
    localparam int P_MEM    = 3;
    localparam int P_WB     = 4;
    localparam int P_TRAP   = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = '0;
    logic          br_taken = 1'b0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          imem_req, ir_we, pc_we, alu_b_sel, dmem_rd, dmem_wr, reg_we, trap;
    logic [1:0]    pc_sel, alu_op, wb_sel, trap_cause;
    logic [CW-1:0] instret;
    logic [2:0]    state_o;
    logic [15:0]   obs;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    logic [6:0] legal_ops [7] = '{OP_R, OP_OPIMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI};

    multicycle_ctrl #(
        .MEM_TIMEOUT(T),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .br_taken  (br_taken),
        .imem_ready(imem_ready),
        .dmem_ready(dmem_ready),
        .imem_req  (imem_req),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .alu_b_sel (alu_b_sel),
        .alu_op    (alu_op),
        .dmem_rd   (dmem_rd),
        .dmem_wr   (dmem_wr),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .trap      (trap),
        .trap_cause(trap_cause),
        .instret   (instret),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    assign obs = {imem_req, ir_we, pc_we, pc_sel, alu_b_sel, alu_op,
                  dmem_rd, dmem_wr, reg_we, wb_sel, state_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        bit ok;
        ok = 1'b0;
        foreach (legal_ops[i]) if (legal_ops[i] == op) ok = 1'b1;
        return ok;
    endfunction

    // Expected control vector for one cycle, straight from the per-class rules
    function automatic logic [15:0] expect_ctl(input int ph, input logic [6:0] op,
                                               input bit last_fetch, input bit taken);
        logic       req, irw, pcw, bsel, drd, dwr, rwe;
        logic [1:0] psel, aop, wsel;
        req = 0; irw = 0; pcw = 0; bsel = 0; drd = 0; dwr = 0; rwe = 0;
        psel = 0; aop = 0; wsel = 0;
        case (ph)
            P_FETCH: begin
                req = 1;
                irw = last_fetch;
            end
            P_EXEC: begin
                bsel = (op == OP_OPIMM) || (op == OP_LOAD) || (op == OP_STORE);
                if (op == OP_R || op == OP_OPIMM) aop = 2'd1;
                else if (op == OP_BRANCH) aop = 2'd2;
            end
            P_MEM: begin
                drd = (op == OP_LOAD);
                dwr = (op == OP_STORE);
            end
            P_WB: begin
                pcw  = 1;
                psel = ((op == OP_JAL) || (op == OP_BRANCH && taken)) ? 2'd1 : 2'd0;
                rwe  = !((op == OP_STORE) || (op == OP_BRANCH));
                wsel = (op == OP_LOAD) ? 2'd1 : (op == OP_JAL) ? 2'd2 : (op == OP_LUI) ? 2'd3 : 2'd0;
            end
            default: begin
            end
        endcase
        return {req, irw, pcw, psel, bsel, aop, drd, dwr, rwe, wsel, 3'(ph)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("rst_ctl", 32'(obs), 32'(0));
            check("rst_trap", 32'({trap, trap_cause}), 32'(0));
            check("rst_instret", 32'(instret), 32'(0));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_ret = 0;
        $display("reset applied");
    endtask

    task automatic run_instr(input logic [6:0] op, input int lat_i, input int lat_d,
                             input bit taken, input int abort_at, output bit need_rst);
        int ph_q[$];
        int cause;
        int fi;
        int mi;
        int ph;
        bit mem_op;
        mem_op = (op == OP_LOAD) || (op == OP_STORE);
        cause = 0;
        for (int i = 0; i < ((lat_i >= T) ? T : lat_i + 1); i++) ph_q.push_back(P_FETCH);
        if (lat_i >= T) begin
            cause = 2;
        end else begin
            ph_q.push_back(P_DECODE);
            if (!is_legal(op)) begin
                cause = 1;
            end else begin
                ph_q.push_back(P_EXEC);
                if (mem_op) begin
                    for (int i = 0; i < ((lat_d >= T) ? T : lat_d + 1); i++) ph_q.push_back(P_MEM);
                    if (lat_d >= T) cause = 3;
                end
                if (cause == 0) ph_q.push_back(P_WB);
            end
        end
        if (cause != 0) for (int i = 0; i < 4; i++) ph_q.push_back(P_TRAP);
        opcode = op;
        fi = 0;
        mi = 0;
        need_rst = (cause != 0);
        foreach (ph_q[k]) begin
            ph = ph_q[k];
            @(negedge clk);
            imem_ready = (ph == P_FETCH) ? (fi == lat_i) : 1'($urandom);
            dmem_ready = (ph == P_MEM) ? (mi == lat_d) : 1'($urandom);
            br_taken   = (ph == P_EXEC) ? taken : 1'($urandom);
            #1;
            if (k == 0) check("instret", 32'(instret), 32'(exp_ret));
            check("ctl", 32'(obs), 32'(expect_ctl(ph, op, (ph == P_FETCH) && (fi == lat_i), taken)));
            check("trap", 32'({trap, trap_cause}), (ph == P_TRAP) ? 32'(4 + cause) : 32'(0));
            if (ph == P_FETCH) fi++;
            if (ph == P_MEM) mi++;
            if (k == abort_at) begin
                need_rst = 1'b1;
                break;
            end
        end
        if (!need_rst) exp_ret = (exp_ret + 1) % (1 << CW);
        $display("instr op=%07b lat_i=%0d lat_d=%0d taken=%0d abort=%0d cause=%0d cycles=%0d",
                 op, lat_i, lat_d, taken, abort_at, cause, ph_q.size());
    endtask

    task automatic step(input logic [6:0] op, input int lat_i, input int lat_d,
                        input bit taken, input int abort_at);
        bit need_rst;
        run_instr(op, lat_i, lat_d, taken, abort_at, need_rst);
        if (need_rst) do_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] op;
        int lat_i;
        int lat_d;
        int abort_at;
        do_reset();
        step(OP_OPIMM, 0, 0, 0, -1);
        step(OP_LOAD, 0, 3, 0, -1);
        step(OP_BRANCH, 0, 0, 1, -1);
        step(OP_BRANCH, 0, 0, 0, -1);
        step(OP_JAL, 0, 0, 1, -1);
        step(OP_STORE, 1, 2, 0, -1);
        step(OP_LUI, 2, 0, 0, -1);
        step(OP_R, 0, 0, 1, -1);
        step(7'b1111111, 0, 0, 0, -1);
        step(OP_OPIMM, T, 0, 0, -1);
        step(OP_OPIMM, T - 1, 0, 0, -1);
        step(OP_STORE, 0, T, 0, -1);
        step(OP_LOAD, 0, T - 1, 0, -1);
        step(OP_LOAD, 0, 10, 0, 4);
        for (int n = 0; n < 120; n++) begin
            op = legal_ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 99) < 6) begin
                do op = 7'($urandom); while (is_legal(op));
            end
            lat_i = ($urandom_range(0, 99) < 5) ? $urandom_range(T - 1, T) : $urandom_range(0, 3);
            lat_d = ($urandom_range(0, 99) < 5) ? $urandom_range(T - 1, T) : $urandom_range(0, 3);
            abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1;
            step(op, lat_i, lat_d, 1'($urandom), abort_at);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
